// File: rtl/decode_rr_scheduler.sv
// decode_rr_scheduler
//   Round-robin scheduler that shares the decode cloud's fanout lines among
//   FANOUT requesters. It grants one requester at a time and drives the
//   cloud's inpBus/enable pair. Each grant is held for at most HOLD_CYCLES
//   unstalled cycles. One idle (GAP) cycle always separates consecutive grants.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no grant; arbitrate each unstalled cycle
//   ACTIVE | enable high, inpBus/grant_onehot hold the granted line
//   GAP    | one enable-low cycle after a grant; arbitrate like IDLE
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   req          in   [FANOUT-1:0] request vector, bit i = requester i
//   stall        in   freezes scheduling while high
//   inpBus       out  [IO_SIZE-1:0] encoded index of the granted line
//   enable       out  grant active
//   grant_onehot out  [FANOUT-1:0] one-hot copy of the grant, zero when idle
//   busy         out  high in ACTIVE
//   grant_count  out  [15:0] saturating count of grants issued
module decode_rr_scheduler #(
  parameter int FANOUT      = 64,
  parameter int IO_SIZE     = $clog2(FANOUT),
  parameter int HOLD_CYCLES = 4,
  parameter int HOLD_W      = $clog2(HOLD_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FANOUT-1:0]  req,
  input  logic               stall,
  output logic [IO_SIZE-1:0] inpBus,
  output logic               enable,
  output logic [FANOUT-1:0]  grant_onehot,
  output logic               busy,
  output logic [15:0]        grant_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IO_SIZE-1:0]  bus_q, bus_d;
  logic                en_q, en_d;
  logic [FANOUT-1:0]   onehot_q, onehot_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [IO_SIZE-1:0]  ptr_q, ptr_d;
  logic [15:0]         gcnt_q, gcnt_d;

  logic                win_found;
  logic [IO_SIZE-1:0]  win_idx;
  int                  idx_int;

  // Rotating search starting at ptr_q. The index is wrapped by compare rather
  // than by bit truncation, so non-power-of-2 FANOUT never yields an index
  // beyond FANOUT-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx_int   = 0;
    for (int k = 0; k < FANOUT; k++) begin
      idx_int = int'(ptr_q) + k;
      if (idx_int >= FANOUT) idx_int = idx_int - FANOUT;
      if (!win_found && req[idx_int[IO_SIZE-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx_int[IO_SIZE-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    bus_d    = bus_q;
    en_d     = en_q;
    onehot_d = onehot_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    gcnt_d   = gcnt_q;
    case (state_q)
      S_IDLE, S_GAP: begin
        en_d     = 1'b0;
        onehot_d = '0;
        if (!stall && win_found) begin
          state_d  = S_ACTIVE;
          bus_d    = win_idx;
          en_d     = 1'b1;
          onehot_d = {{(FANOUT-1){1'b0}}, 1'b1} << win_idx;
          cnt_d    = HOLD_W'(HOLD_CYCLES - 1);
          ptr_d    = (win_idx == IO_SIZE'(FANOUT - 1)) ? '0 : win_idx + 1'b1;
          gcnt_d   = (gcnt_q == 16'hFFFF) ? gcnt_q : gcnt_q + 16'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (!stall) begin
          // Release on hold expiry or when the granted requester lets go.
          if (cnt_q == '0 || !req[bus_q]) begin
            state_d  = S_GAP;
            en_d     = 1'b0;
            onehot_d = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: begin
        state_d  = S_IDLE;
        en_d     = 1'b0;
        onehot_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      bus_q    <= '0;
      en_q     <= 1'b0;
      onehot_q <= '0;
      cnt_q    <= '0;
      ptr_q    <= '0;
      gcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      bus_q    <= bus_d;
      en_q     <= en_d;
      onehot_q <= onehot_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      gcnt_q   <= gcnt_d;
    end
  end

  assign inpBus       = bus_q;
  assign enable       = en_q;
  assign grant_onehot = onehot_q;
  assign busy         = (state_q == S_ACTIVE);
  assign grant_count  = gcnt_q;

endmodule

// File: tb/tb_decode_rr_scheduler.sv
// Testbench for decode_rr_scheduler (FANOUT=8, HOLD_CYCLES=4): directed
// scenarios followed by randomized traffic, all compared every cycle against
// a behavioural model of the grant rules.
module tb_decode_rr_scheduler;
  localparam int N = 8;
  localparam int H = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         stall = 1'b0;
  logic [2:0]   inpBus;
  logic         enable;
  logic [N-1:0] grant_onehot;
  logic         busy;
  logic [15:0]  grant_count;

  decode_rr_scheduler #(.FANOUT(N), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .stall(stall),
    .inpBus(inpBus), .enable(enable), .grant_onehot(grant_onehot),
    .busy(busy), .grant_count(grant_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: granted = a grant is being served; left = enable cycles still
  // allowed for this grant including the current one.
  bit granted;
  int m_bus, m_left, m_ptr, m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    granted = 0; m_bus = 0; m_left = 0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    int w;
    if (granted) begin
      if (!stall) begin
        if (m_left == 1 || !req[m_bus]) granted = 0;
        else m_left--;
      end
    end else if (!stall && req != 0) begin
      w = -1;
      for (int i = 0; i < N && w < 0; i++)
        if (req[(m_ptr + i) % N]) w = (m_ptr + i) % N;
      granted = 1;
      m_bus   = w;
      m_left  = H;
      m_ptr   = (w + 1) % N;
      if (m_cnt < 16'hFFFF) m_cnt++;
    end
  endtask

  task automatic check_all();
    logic [N-1:0] exp_oh;
    exp_oh = granted ? (N'(1) << m_bus) : '0;
    chk("enable", 32'(enable), 32'(granted));
    chk("busy", 32'(busy), 32'(granted));
    chk("inpBus", 32'(inpBus), 32'(m_bus));
    chk("grant_onehot", 32'(grant_onehot), 32'(exp_oh));
    chk("grant_count", 32'(grant_count), 32'(m_cnt));
    chk("onehot_vs_enable", 32'(grant_onehot), enable ? 32'(N'(1) << inpBus) : 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int order[$];
    int exp_order[6];
    int en_cycles;
    bit prev_en;

    // Reset and idle
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // Single requester held: 4 enable cycles then one GAP, repeating
    req = 8'b0000_0100;
    for (int i = 0; i < 15; i++) step();
    chk("single_grant_count", 32'(grant_count), 32'd3);
    req = '0;
    for (int i = 0; i < 6; i++) step();

    // Round-robin fairness from a fresh pointer
    do_reset();
    req = 8'b1000_0011;
    prev_en = 0;
    for (int i = 0; i < 60 && order.size() < 6; i++) begin
      step();
      if (enable && !prev_en) order.push_back(int'(inpBus));
      prev_en = enable;
    end
    exp_order = '{0, 1, 7, 0, 1, 7};
    chk("rr_grants_seen", 32'(order.size()), 32'd6);
    for (int i = 0; i < 6 && i < order.size(); i++)
      chk($sformatf("rr_order[%0d]", i), 32'(order[i]), 32'(exp_order[i]));
    req = '0;
    for (int i = 0; i < 6; i++) step();

    // Early release: grant to 5, req[5] drops in its 2nd ACTIVE cycle
    do_reset();
    req = 8'h60;
    step();
    chk("early_first", 32'(inpBus), 32'd5);
    step();
    req = 8'h40;
    step();
    chk("early_gap_enable", 32'(enable), 32'd0);
    step();
    chk("early_next", {31'd0, enable} << 3 | 32'(inpBus), 32'h0000_000E);
    req = '0;
    for (int i = 0; i < 6; i++) step();

    // Stall for 3 cycles while the hold counter is at 2
    req = 8'h01;
    en_cycles = 0;
    step(); if (enable) en_cycles++;
    step(); if (enable) en_cycles++;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); if (enable) en_cycles++; end
    stall = 1'b0;
    for (int i = 0; i < 20 && enable; i++) begin step(); if (enable) en_cycles++; end
    chk("stall_enable_cycles", 32'(en_cycles), 32'd7);
    req = '0;
    for (int i = 0; i < 4; i++) step();

    // Stall in IDLE blocks all grants
    req = 8'hFF;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("stall_idle_enable", 32'(enable), 32'd0);
    stall = 1'b0;
    step();
    chk("stall_release_grant", 32'(enable), 32'd1);

    // Async reset between clock edges mid-grant
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_enable", 32'(enable), 32'd0);
    chk("async_onehot", 32'(grant_onehot), 32'd0);
    model_reset();
    check_all();
    #3;
    rst_n = 1'b1;
    req = 8'h10;
    step();
    chk("post_reset_grant", {31'd0, enable} << 3 | 32'(inpBus), 32'h0000_000C);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 3))
        0: req = N'($urandom);
        1: req = req & ~(N'(1) << $urandom_range(0, N - 1));
        2: req = req | (N'(1) << $urandom_range(0, N - 1));
        default: ;
      endcase
      stall = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
